decode_issue_ctrl: RTL and testbench
====================================

// Module: decode_issue_ctrl
// PURPOSE
//   Sequences the decode stage: holds the IF/ID instruction register that feeds the decoder.
//   Uses the decoded rd/rs1/rs2/opcode fields to detect load-use hazards through a pending-load scoreboard.
//   Issues instructions to EX with a valid/ready handshake. Sits between fetch and the ID/EX register.
// PARAMETERS
//   XLEN      32   width of pc and instruction
//   NUM_REGS  32   architectural registers tracked by scoreboard (x0 never tracked)
// PORTS
//   clk          in   1     clock
//   rst          in   1     synchronous active-high reset
//   if_valid     in   1     fetch presents instruction
//   if_ready     out  1     ID register can accept this cycle
//   if_instr     in   XLEN  fetched instruction
//   if_pc        in   XLEN  fetched pc
//   flush        in   1     redirect from EX: kill held instruction
//   dec_instr    out  XLEN  held instruction, drives decoder instr input
//   dec_pc       out  XLEN  held pc
//   dec_opcode   in   7     decoder opcode of dec_instr
//   dec_rd       in   5     decoder rd
//   dec_rs1      in   5     decoder rs1
//   dec_rs2      in   5     decoder rs2
//   ex_valid     out  1     issue request to EX
//   ex_ready     in   1     EX accepts
//   wb_ld_valid  in   1     load result written back this cycle
//   wb_ld_rd     in   5     destination of that load
//   stall        out  1     held instr blocked by hazard (ifdef: also counted)
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-high (clk, rst).
//   - Reset: state=EMPTY, dec_instr=32'h0000_0013 (NOP), dec_pc=0, pending=0, ex_valid=0, stall=0.
//   - FSM EMPTY: if_ready=1; if_valid && !flush -> latch instr/pc, go FULL.
//   - FSM FULL: issue = ex_valid && ex_ready. On issue: if_valid latches the next instr (stay FULL), else go EMPTY.
//   - if_ready = !flush && (state==EMPTY || issue); combinational from ex_ready.
//   - Operand use: rs1 for opcodes 0110011,0010011,0000011,1100111,0100011,1100011; rs2 for 0110011,0100011,1100011.
//     LUI/AUIPC/JAL use neither.
//   - hazard = FULL && ((use_rs1 && rs1!=0 && busy[rs1]) || (use_rs2 && rs2!=0 && busy[rs2])).
//   - busy[r] = pending[r] && !(wb_ld_valid && wb_ld_rd==r): a same-cycle writeback clears the hazard.
//   - ex_valid = FULL && !hazard && !flush; stall = FULL && hazard && !flush.
//   - ex_valid is held stable with the same instr until ex_ready (no retraction except flush).
//   - Scoreboard set: on issue of opcode 0000011 with rd!=0 -> pending[rd]<=1 next cycle.
//   - Scoreboard clear: wb_ld_valid -> pending[wb_ld_rd]<=0. Set and clear of the same reg in one cycle: set wins.
//   - Loads are not limited; a second load to a pending reg simply keeps the bit set.
//   - Flush: highest priority; state->EMPTY, dec_instr->NOP next cycle, no issue, no latch.
//     pending is NOT cleared (in-flight loads still write back).
//   - rst mid-operation: all state incl. pending returns to reset values next edge.
//   - Latency: fetch accept -> ex_valid 1 cycle min; throughput 1 instr/cycle absent hazards.
// CONFIGURATION
//   ID_STALL_CNT_EN defined: adds output stall_cycles [31:0]; +1 each cycle stall=1.
//     Reset 0, wraps 2^32-1 -> 0, unaffected by flush.
//   ID_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//   - Reset: rst 1 cycle -> ex_valid=0, if_ready=1, dec_instr=0x00000013, pending==0.
//   - Streaming: 3 back-to-back ADDIs, ex_ready=1 -> ex_valid 3 consecutive cycles, pcs 0,4,8, no stall.
//   - Load-use: issue lw x5; next add x6,x5,x1 -> stall=1 until wb_ld_valid rd=5.
//     add issues in the wb cycle (bypass clear).
//   - Backpressure: ex_ready=0 for 4 cycles with FULL -> ex_valid held, dec_instr stable, if_ready=0;
//     release -> issue plus next accept same cycle.
//   - Flush: FULL + flush=1 while if_valid=1 -> no issue, if_ready=0; next cycle EMPTY, dec_instr NOP.
//     pending[5] kept.
//   - Set/clear collision: issue lw x7 while wb_ld_valid rd=7 -> pending[7]=1 after edge.
//     With ID_STALL_CNT_EN, 3 stall cycles -> stall_cycles=3.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue_ctrl
//  Purpose  : IF/ID holding register, load-use hazard scoreboard and
//             valid/ready issue sequencing towards EX.
//             Optional stall_cycles counter enabled by ID_STALL_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module decode_issue_ctrl #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    input  logic [6:0]      dec_opcode,
    input  logic [4:0]      dec_rd,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    output logic            ex_valid,
    input  logic            ex_ready,
    input  logic            wb_ld_valid,
    input  logic [4:0]      wb_ld_rd,
    output logic            stall
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam logic [XLEN-1:0] C_NOP       = XLEN'(32'h0000_0013);
    localparam logic [6:0]      C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]      C_OP_REG    = 7'b0110011;
    localparam logic [6:0]      C_OP_IMM    = 7'b0010011;
    localparam logic [6:0]      C_OP_JALR   = 7'b1100111;
    localparam logic [6:0]      C_OP_STORE  = 7'b0100011;
    localparam logic [6:0]      C_OP_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [XLEN-1:0]       r_instr;
    logic [XLEN-1:0]       r_pc;
    logic [NUM_REGS-1:0]   r_pending;
    logic [NUM_REGS-1:0]   w_busy;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;
    logic                  w_use_rs1;
    logic                  w_use_rs2;
    logic                  w_hazard;
    logic                  w_ex_valid;
    logic                  w_stall;
    logic                  w_issue;
    logic                  w_if_ready;
    logic                  w_accept;

    // Operand usage by opcode; LUI/AUIPC/JAL fall through to "no use".
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (dec_opcode)
            C_OP_REG, C_OP_STORE, C_OP_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            C_OP_IMM, C_OP_LOAD, C_OP_JALR: begin
                w_use_rs1 = 1'b1;
            end
            default: begin
                w_use_rs1 = 1'b0;
                w_use_rs2 = 1'b0;
            end
        endcase
    end

    // A load writing back this very cycle no longer blocks its consumer.
    always_comb begin
        w_busy = '0;
        w_set  = '0;
        w_clr  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_clr[i]  = wb_ld_valid && (wb_ld_rd == 5'(i));
            w_busy[i] = r_pending[i] && !w_clr[i];
            w_set[i]  = w_issue && (dec_opcode == C_OP_LOAD) && (dec_rd == 5'(i));
        end
    end

    always_comb begin
        w_hazard   = (r_state == FULL) &&
                     ((w_use_rs1 && (dec_rs1 != 5'd0) && w_busy[dec_rs1]) ||
                      (w_use_rs2 && (dec_rs2 != 5'd0) && w_busy[dec_rs2]));
        w_ex_valid = (r_state == FULL) && !w_hazard && !flush;
        w_stall    = (r_state == FULL) &&  w_hazard && !flush;
        w_issue    = w_ex_valid && ex_ready;
        w_if_ready = !flush && ((r_state == EMPTY) || w_issue);
        w_accept   = if_valid && w_if_ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) w_state_nxt = FULL;
                FULL:  if (w_issue)  w_state_nxt = w_accept ? FULL : EMPTY;
                default:             w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= C_NOP;
            r_pc    <= '0;
        end else if (flush) begin
            r_instr <= C_NOP;
        end else if (w_accept) begin
            r_instr <= if_instr;
            r_pc    <= if_pc;
        end
    end

    // Set has priority over a same-cycle writeback clear of the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_set[i]) begin
                    r_pending[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign if_ready  = w_if_ready;
    assign dec_instr = r_instr;
    assign dec_pc    = r_pc;
    assign ex_valid  = w_ex_valid;
    assign stall     = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_issue_ctrl
//  Purpose  : Scoreboard bench for decode_issue_ctrl (directed vectors).
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_issue_ctrl;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        ex_valid;
    logic        ex_ready;
    logic        wb_ld_valid;
    logic [4:0]  wb_ld_rd;
    logic        stall;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] stall_base;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] exp_q[$];
    int          issue_cyc[$];

    decode_issue_ctrl #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .flush       (flush),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_opcode  (dec_opcode),
        .dec_rd      (dec_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .wb_ld_valid (wb_ld_valid),
        .wb_ld_rd    (wb_ld_rd),
        .stall       (stall)
`ifdef ID_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // Minimal decoder field extraction feeding the DUT.
    assign dec_opcode = dec_instr[6:0];
    assign dec_rd     = dec_instr[11:7];
    assign dec_rs1    = dec_instr[19:15];
    assign dec_rs2    = dec_instr[24:20];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1);
    end

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(logic [4:0] rs2, logic [4:0] rs1,
                                          logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every issue handshake pops the oldest expected {pc, instr}.
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            issue_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {dec_pc, dec_instr}, 64'h0);
            end else begin
                check("issue_pc_instr", {dec_pc, dec_instr}, exp_q.pop_front());
            end
        end
    end

    // Entered and left at posedge+1; presents one fetch until it is taken.
    task automatic send(logic [31:0] pc, logic [31:0] instr, bit expect_issue);
        int n;
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
        n = 0;
        forever begin
            @(negedge clk);
            if (if_ready) break;
            n++;
            if (n > 20) begin
                check("send_timeout", 64'(n), 64'h0);
                break;
            end
            @(posedge clk); #1;
        end
        if (expect_issue) exp_q.push_back({pc, instr});
        @(posedge clk); #1;
        if_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] lw5, lw7, add_dep, addi_a, addi_b;
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        ex_ready = 1'b0; wb_ld_valid = 1'b0; wb_ld_rd = '0;
        lw5     = enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011);
        lw7     = enc_i(12'd4, 5'd2, 3'd2, 5'd7, 7'b0000011);
        add_dep = enc_r(5'd1, 5'd5, 5'd6);
        addi_a  = enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'b0010011);
        addi_b  = enc_i(12'd2, 5'd0, 3'd0, 5'd2, 7'b0010011);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_if_ready", 64'(if_ready), 64'd1);
        check("rst_dec_instr", 64'(dec_instr), 64'(C_NOP));
        check("rst_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;

        // Streaming: three ADDIs, one issue per cycle
        ex_ready = 1'b1;
        send(32'h0, addi_a, 1'b1);
        send(32'h4, addi_b, 1'b1);
        send(32'h8, enc_i(12'd3, 5'd0, 3'd0, 5'd3, 7'b0010011), 1'b1);
        idle(2);
        check("stream_count", 64'(issue_cyc.size()), 64'd3);
        check("stream_back_to_back", 64'(issue_cyc[2] - issue_cyc[0]), 64'd2);

        // Load-use: add x6,x5,x1 waits for the x5 writeback and issues in that cycle
        send(32'h100, lw5, 1'b1);
        send(32'h104, add_dep, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ldu_stall", 64'(stall), 64'd1);
            check("ldu_no_issue", 64'(ex_valid), 64'd0);
            @(posedge clk); #1;
        end
        wb_ld_valid = 1'b1; wb_ld_rd = 5'd5;
        @(negedge clk);
        check("ldu_bypass_stall", 64'(stall), 64'd0);
        check("ldu_bypass_issue", 64'(ex_valid), 64'd1);
        @(posedge clk); #1;
        wb_ld_valid = 1'b0;
        idle(1);

        // Backpressure: held for 4 cycles, then issue and accept together
        ex_ready = 1'b0;
        send(32'h200, addi_a, 1'b1);
        if_valid = 1'b1; if_pc = 32'h204; if_instr = addi_b;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ex_valid", 64'(ex_valid), 64'd1);
            check("bp_if_ready", 64'(if_ready), 64'd0);
            check("bp_dec_instr", 64'(dec_instr), 64'(addi_a));
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("bp_release_if_ready", 64'(if_ready), 64'd1);
        exp_q.push_back({32'h204, addi_b});
        @(posedge clk); #1;
        if_valid = 1'b0;
        idle(2);

        // Flush: held instr killed, incoming fetch dropped, pending[5] kept
        send(32'h300, lw5, 1'b1);
        idle(2);
        ex_ready = 1'b0;
        send(32'h304, enc_i(12'd9, 5'd0, 3'd0, 5'd9, 7'b0010011), 1'b0);
        if_valid = 1'b1; if_pc = 32'h308; if_instr = addi_b; flush = 1'b1;
        @(negedge clk);
        check("flush_ex_valid", 64'(ex_valid), 64'd0);
        check("flush_if_ready", 64'(if_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        check("flush_empty_if_ready", 64'(if_ready), 64'd1);
        check("flush_dec_nop", 64'(dec_instr), 64'(C_NOP));
        @(posedge clk); #1;
        ex_ready = 1'b1;
        send(32'h30c, add_dep, 1'b1);
        @(negedge clk);
        check("flush_pending_kept", 64'(stall), 64'd1);
        @(posedge clk); #1;
        wb_ld_valid = 1'b1; wb_ld_rd = 5'd5;
        @(negedge clk);
        check("flush_wb_issue", 64'(ex_valid), 64'd1);
        @(posedge clk); #1;
        wb_ld_valid = 1'b0;
        idle(1);

        // Set/clear collision on x7: set wins, consumer (rs2=x7) stalls
        send(32'h400, lw7, 1'b1);
        wb_ld_valid = 1'b1; wb_ld_rd = 5'd7;
        @(negedge clk);
        check("coll_lw_issue", 64'(ex_valid), 64'd1);
        @(posedge clk); #1;
        wb_ld_valid = 1'b0;
`ifdef ID_STALL_CNT_EN
        stall_base = stall_cycles;
`endif
        send(32'h404, enc_r(5'd7, 5'd0, 5'd8), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("coll_stall", 64'(stall), 64'd1);
            @(posedge clk); #1;
        end
        wb_ld_valid = 1'b1; wb_ld_rd = 5'd7;
        @(negedge clk);
        check("coll_wb_issue", 64'(ex_valid), 64'd1);
        @(posedge clk); #1;
        wb_ld_valid = 1'b0;
`ifdef ID_STALL_CNT_EN
        check("stall_cycles_delta", 64'(stall_cycles - stall_base), 64'd3);
`endif
        idle(1);

        // Reset mid-operation clears pending
        send(32'h500, lw5, 1'b1);
        idle(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(32'h504, add_dep, 1'b1);
        @(negedge clk);
        check("rst_pending_stall", 64'(stall), 64'd0);
        check("rst_pending_issue", 64'(ex_valid), 64'd1);
        @(posedge clk); #1;
        idle(2);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
